multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum wait cycles for mem_ready before a trap (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port instr, input, 32, the current instruction-register contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
REQ-005 SHALL have port mem_ready, input, 1, memory completion for the current mem_req.
REQ-006 SHALL have port alu_zero, input, 1, ALU result-equals-zero flag.
REQ-007 SHALL have outputs mem_req, mem_we, i_or_d (0=PC, 1=ALUOut), ir_write, pc_write and reg_write, each 1 bit.
REQ-008 SHALL have outputs alu_src_a [1:0] (00 PC, 01 oldPC, 10 rs1) and alu_src_b [1:0] (00 rs2, 01 const 4, 10 imm).
REQ-009 SHALL have output alu_op [3:0] with AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
REQ-010 SHALL have output pc_src [1:0] (00 ALU result, 01 ALUOut) and output wb_sel [1:0] (00 ALUOut, 01 mem data, 10 PC).
REQ-011 SHALL have outputs instr_retired (1 bit), trap (1 bit), trap_cause [1:0] (01 illegal, 10 timeout) and state [3:0] for debug.

Function
REQ-012 SHALL implement the following FSM states: FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP.
REQ-013 Any output not listed for a state SHALL be 0 in that state.
REQ-014 FETCH SHALL assert mem_req with i_or_d=0, and SHALL stay in FETCH while mem_ready=0.
REQ-015 In the FETCH cycle where mem_ready=1, the block SHALL also assert ir_write and pc_write with pc_src=00, alu_src_a=00, alu_src_b=01 and alu_op=ADD, then go to DECODE.
REQ-016 DECODE SHALL drive alu_src_a=01, alu_src_b=10 and alu_op=ADD, which precomputes the branch/jump target into ALUOut.
REQ-017 DECODE next state SHALL be: opcode 0000011 or 0100011 -> MEMADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; any other opcode -> TRAP with cause 01.
REQ-018 MEMADDR SHALL drive alu_src_a=10, alu_src_b=10 and alu_op=ADD, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-019 MEMREAD SHALL assert mem_req with i_or_d=1 and wait for mem_ready, then go to MEMWB.
REQ-020 MEMWB SHALL assert reg_write with wb_sel=01 and instr_retired, then go to FETCH.
REQ-021 MEMWRITE SHALL assert mem_req, mem_we and i_or_d=1, and wait for mem_ready; in the mem_ready cycle it SHALL assert instr_retired and go to FETCH.
REQ-022 EXEC_R SHALL drive alu_src_a=10 and alu_src_b=00, with the funct3/funct7 map: 000/0000000 ADD; 000/0100000 SUB; 010 SLT; 110 OR; 111 AND.
REQ-023 EXEC_I SHALL drive alu_src_a=10 and alu_src_b=10, with the funct3 map: 000 ADD; 010 SLT; 110 OR; 111 AND.
REQ-024 Unmapped funct combinations in EXEC_R or EXEC_I SHALL go to TRAP with cause 01; mapped combinations SHALL go to ALUWB.
REQ-025 ALUWB SHALL assert reg_write with wb_sel=00 and instr_retired, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=SUB and pc_src=01.
REQ-027 In BRANCH, pc_write SHALL be 1 when (funct3=000 and alu_zero) or (funct3=001 and not alu_zero); funct3 other than 000/001 SHALL go to TRAP with cause 01, and all other cases SHALL go to FETCH with instr_retired=1.
REQ-028 JAL SHALL assert pc_write with pc_src=01, and reg_write with wb_sel=10 (rd gets PC+4), plus instr_retired, then go to FETCH.
REQ-029 SHALL keep an 8-bit wait counter that clears on entry to FETCH, MEMREAD or MEMWRITE and increments each cycle mem_ready=0 in those states.
REQ-030 When the wait counter reaches MEM_TIMEOUT with mem_ready=0, the block SHALL go to TRAP with cause 10 and drop mem_req on the next cycle.
REQ-031 If mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, the completion SHALL win and no trap SHALL occur.
REQ-032 mem_ready outside FETCH, MEMREAD and MEMWRITE SHALL be ignored.
REQ-033 TRAP SHALL be absorbing: trap=1, trap_cause held, all write and request strobes 0, until reset.
REQ-034 instr_retired SHALL be exactly a one-cycle pulse per completed instruction and SHALL never be asserted in TRAP.

Reset
REQ-035 When reset=1 at a clock edge, the next state SHALL be FETCH, the wait counter SHALL be 0, and trap_cause SHALL be 00, regardless of current state, including mid-memory-wait and TRAP.
REQ-036 While in FETCH after reset, outputs SHALL be mem_req=1 with all other strobes 0, trap=0 and state=FETCH.

Verification
REQ-037 add x3,x1,x2 with mem_ready=1 every cycle -> FETCH, DECODE, EXEC_R, ALUWB; alu_op=0010; reg_write=1 and instr_retired=1 in cycle 4.
REQ-038 lw with mem_ready delayed 3 cycles in both FETCH and MEMREAD -> 11 cycles total, reg_write with wb_sel=01 exactly once, no trap.
REQ-039 beq with alu_zero=1 -> pc_write=1, pc_src=01 in BRANCH; with alu_zero=0 -> pc_write=0; both retire in 3 cycles.
REQ-040 opcode 1111111 -> TRAP after DECODE, trap_cause=01, no further mem_req, until reset.
REQ-041 MEM_TIMEOUT=4 and mem_ready held 0 in MEMWRITE -> TRAP with cause 10 after 4 wait cycles; mem_ready=1 on the 4th cycle -> normal retire instead.
REQ-042 reset asserted for one cycle during MEMREAD -> next state FETCH, mem_we=0, and no reg_write from the aborted load.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32-subset control unit: sequences fetch, decode, memory,
// ALU, branch and jump phases, with a memory-wait timeout that traps.
//
// state (code) | meaning
// FETCH    (0) | request instruction word, write IR and PC+4 on ready
// DECODE   (1) | precompute branch/jump target into ALUOut, dispatch
// MEMADDR  (2) | compute rs1+imm load/store address
// MEMREAD  (3) | load data request, wait for ready
// MEMWB    (4) | write loaded data to rd, retire
// MEMWRITE (5) | store request, wait for ready, retire on ready
// EXEC_R   (6) | register-register ALU op
// EXEC_I   (7) | register-immediate ALU op
// ALUWB    (8) | write ALUOut to rd, retire
// BRANCH   (9) | compare rs1-rs2, conditionally load target into PC
// JAL     (10) | jump to target, rd gets PC+4, retire
// TRAP    (11) | absorbing fault state until reset
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic        instr_retired,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // last count value at which a still-missing ready becomes a timeout
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] wait_cnt;
  logic       mem_wait;
  logic       timeout;
  logic       legal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign mem_wait   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // a ready in the same cycle beats the timeout, so only a missing ready counts
  assign timeout    = !mem_ready && (wait_cnt == TMO_LAST);
  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

  // state, trap cause and wait counter registers; counter restarts on every entry to a wait state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cause_q  <= 2'b00;
      wait_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (mem_wait && !mem_ready && (state_d == state_q))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  // next-state and per-state control outputs
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_AND;
    pc_src        = 2'b00;
    wb_sel        = 2'b00;
    instr_retired = 1'b0;
    legal         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          state_d   = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        wb_sel        = 2'b01;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              alu_op = ALU_ADD;
              legal  = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              alu_op = ALU_SUB;
              legal  = 1'b1;
            end
          end
          3'b010: begin alu_op = ALU_SLT; legal = 1'b1; end
          3'b110: begin alu_op = ALU_OR;  legal = 1'b1; end
          3'b111: begin alu_op = ALU_AND; legal = 1'b1; end
          default: legal = 1'b0;
        endcase
        state_d = legal ? S_ALUWB : S_TRAP;
        if (!legal) cause_d = 2'b01;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (funct3)
          3'b000: begin alu_op = ALU_ADD; legal = 1'b1; end
          3'b010: begin alu_op = ALU_SLT; legal = 1'b1; end
          3'b110: begin alu_op = ALU_OR;  legal = 1'b1; end
          3'b111: begin alu_op = ALU_AND; legal = 1'b1; end
          default: legal = 1'b0;
        endcase
        state_d = legal ? S_ALUWB : S_TRAP;
        if (!legal) cause_d = 2'b01;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        wb_sel        = 2'b00;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          pc_write      = (funct3 == 3'b000) ? alu_zero : !alu_zero;
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_JAL: begin
        pc_write      = 1'b1;
        pc_src        = 2'b01;
        reg_write     = 1'b1;
        wb_sel        = 2'b10;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: builds an expected per-cycle
// trace for each instruction from its phase sequence and memory latencies,
// then plays the trace against the DUT.
module tb_multicycle_control;

  localparam int TMO = 4;

  localparam logic [3:0] ST_FETCH = 0, ST_DECODE = 1, ST_MEMADDR = 2, ST_MEMREAD = 3,
                         ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXEC_R = 6, ST_EXEC_I = 7,
                         ST_ALUWB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_TRAP = 11;
  localparam logic [3:0] K_AND = 4'b0000, K_OR = 4'b0001, K_ADD = 4'b0010,
                         K_SUB = 4'b0110, K_SLT = 4'b0111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] op;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic       retired;
    logic       trap;
    logic [1:0] cause;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    bit          rst;
    bit          chk;
    logic [31:0] ins;
    bit          rdy;
    bit          zero;
    ctl_t        exp;
  } vec_t;

  vec_t vq[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready, alu_zero;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, pc_src, wb_sel, trap_cause;
  logic [3:0]  alu_op, state;
  logic        instr_retired, trap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .wb_sel(wb_sel), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  function automatic ctl_t idle(input logic [3:0] st);
    ctl_t c = '0;
    c.st = st;
    return c;
  endfunction

  task automatic push(input logic [31:0] ins, input bit rdy, input bit z, input ctl_t e);
    vec_t v;
    v.rst = 0; v.chk = 1; v.ins = ins; v.rdy = rdy; v.zero = z; v.exp = e;
    vq.push_back(v);
  endtask

  // reset cycle; ready deliberately high so an in-flight completion must lose to reset
  task automatic push_rst(input logic [31:0] ins);
    vec_t v;
    v.rst = 1; v.chk = 0; v.ins = ins; v.rdy = 1; v.zero = 1'($urandom); v.exp = '0;
    vq.push_back(v);
  endtask

  task automatic trap_tail(input logic [31:0] ins, input logic [1:0] cause);
    ctl_t t = idle(ST_TRAP);
    t.trap  = 1;
    t.cause = cause;
    for (int i = 0; i < 3; i++) push(ins, 1'($urandom), 1'($urandom), t);
    push_rst(ins);
  endtask

  // lat = number of cycles ready stays low before it rises
  task automatic mem_phase(input logic [31:0] ins, input logic [3:0] st, input int lat,
                           input ctl_t done, output bit timed_out);
    ctl_t w;
    int   n;
    w = idle(st);
    w.mem_req = 1;
    w.mem_we  = (st == ST_MEMWRITE);
    w.i_or_d  = (st != ST_FETCH);
    n = (lat < TMO) ? lat : TMO;
    for (int i = 0; i < n; i++) push(ins, 0, 1'($urandom), w);
    timed_out = (lat >= TMO);
    if (!timed_out) push(ins, 1, 1'($urandom), done);
  endtask

  function automatic bit r_map(input logic [2:0] f3, input logic [6:0] f7, output logic [3:0] op);
    op = K_AND;
    case (f3)
      3'b000: if (f7 == 7'h00) begin op = K_ADD; return 1; end
              else if (f7 == 7'h20) begin op = K_SUB; return 1; end
      3'b010: begin op = K_SLT; return 1; end
      3'b110: begin op = K_OR;  return 1; end
      3'b111: begin op = K_AND; return 1; end
      default: ;
    endcase
    return 0;
  endfunction

  function automatic bit i_map(input logic [2:0] f3, output logic [3:0] op);
    op = K_AND;
    case (f3)
      3'b000: begin op = K_ADD; return 1; end
      3'b010: begin op = K_SLT; return 1; end
      3'b110: begin op = K_OR;  return 1; end
      3'b111: begin op = K_AND; return 1; end
      default: ;
    endcase
    return 0;
  endfunction

  task automatic do_instr(input logic [31:0] ins, input int lf, input int lm, input bit z);
    ctl_t c, w;
    bit   to, ok;
    logic [3:0] op;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    c = idle(ST_FETCH);
    c.mem_req = 1; c.ir_write = 1; c.pc_write = 1; c.src_b = 2'b01; c.op = K_ADD;
    mem_phase(ins, ST_FETCH, lf, c, to);
    if (to) begin trap_tail(ins, 2'b10); return; end
    c = idle(ST_DECODE);
    c.src_a = 2'b01; c.src_b = 2'b10; c.op = K_ADD;
    push(ins, 1'($urandom), 1'($urandom), c);
    case (opc)
      7'b0000011, 7'b0100011: begin
        c = idle(ST_MEMADDR);
        c.src_a = 2'b10; c.src_b = 2'b10; c.op = K_ADD;
        push(ins, 1'($urandom), 1'($urandom), c);
        if (opc == 7'b0000011) begin
          w = idle(ST_MEMREAD); w.mem_req = 1; w.i_or_d = 1;
          mem_phase(ins, ST_MEMREAD, lm, w, to);
          if (to) begin trap_tail(ins, 2'b10); return; end
          c = idle(ST_MEMWB); c.reg_write = 1; c.wb_sel = 2'b01; c.retired = 1;
          push(ins, 1'($urandom), 1'($urandom), c);
        end else begin
          w = idle(ST_MEMWRITE); w.mem_req = 1; w.mem_we = 1; w.i_or_d = 1; w.retired = 1;
          mem_phase(ins, ST_MEMWRITE, lm, w, to);
          if (to) trap_tail(ins, 2'b10);
        end
      end
      7'b0110011, 7'b0010011: begin
        if (opc == 7'b0110011) begin
          ok = r_map(f3, ins[31:25], op);
          c = idle(ST_EXEC_R); c.src_b = 2'b00;
        end else begin
          ok = i_map(f3, op);
          c = idle(ST_EXEC_I); c.src_b = 2'b10;
        end
        c.src_a = 2'b10; c.op = op;
        push(ins, 1'($urandom), 1'($urandom), c);
        if (!ok) begin trap_tail(ins, 2'b01); return; end
        c = idle(ST_ALUWB); c.reg_write = 1; c.wb_sel = 2'b00; c.retired = 1;
        push(ins, 1'($urandom), 1'($urandom), c);
      end
      7'b1100011: begin
        c = idle(ST_BRANCH);
        c.src_a = 2'b10; c.src_b = 2'b00; c.op = K_SUB; c.pc_src = 2'b01;
        if (f3 == 3'b000 || f3 == 3'b001) begin
          c.pc_write = (f3 == 3'b000) ? z : !z;
          c.retired  = 1;
          push(ins, 1'($urandom), z, c);
        end else begin
          push(ins, 1'($urandom), z, c);
          trap_tail(ins, 2'b01);
        end
      end
      7'b1101111: begin
        c = idle(ST_JAL);
        c.pc_write = 1; c.pc_src = 2'b01; c.reg_write = 1; c.wb_sel = 2'b10; c.retired = 1;
        push(ins, 1'($urandom), 1'($urandom), c);
      end
      default: trap_tail(ins, 2'b01);
    endcase
  endtask

  function automatic bit legal_opc(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opc;
    int          k;
    ins = $urandom;
    k = $urandom_range(0, 7);
    case (k)
      0: opc = 7'b0000011;
      1: opc = 7'b0100011;
      2, 3: opc = 7'b0110011;
      4: opc = 7'b0010011;
      5: opc = 7'b1100011;
      6: opc = 7'b1101111;
      default: begin
        opc = 7'h7F;
        for (int i = 0; i < 8; i++) begin
          logic [6:0] t;
          t = 7'($urandom);
          if (!legal_opc(t)) begin opc = t; break; end
        end
      end
    endcase
    ins[6:0] = opc;
    case ($urandom_range(0, 2))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      default: ;
    endcase
    if (k == 5 && $urandom_range(0, 3) != 0) ins[14:12] = 3'($urandom_range(0, 1));
    return ins;
  endfunction

  initial begin
    ctl_t act, c;
    bit   to;
    int   exp_ret = 0;
    int   got_ret = 0;
    logic [31:0] i_add, i_sub, i_lw, i_sw, i_beq, i_bne, i_jal, i_bad, i_addi;

    i_add  = 32'h002081B3;
    i_sub  = 32'h402081B3;
    i_lw   = 32'h0000A283;
    i_sw   = 32'h0050A023;
    i_beq  = 32'h00208063;
    i_bne  = 32'h00209063;
    i_jal  = 32'h0000006F;
    i_bad  = 32'h0000007F;
    i_addi = 32'h00108093;

    // directed table
    do_instr(i_add, 0, 0, 0);
    do_instr(i_lw, 3, 3, 0);
    do_instr(i_beq, 0, 0, 1);
    do_instr(i_beq, 0, 0, 0);
    do_instr(i_bne, 0, 0, 0);
    do_instr(i_sub, 1, 0, 0);
    do_instr(i_addi, 2, 0, 0);
    do_instr(i_jal, 0, 0, 0);
    do_instr(i_sw, 0, TMO - 1, 0);
    do_instr(i_lw, TMO - 1, TMO - 1, 0);
    do_instr(i_sw, 0, TMO, 0);
    do_instr(i_bad, 0, 0, 0);
    do_instr(i_lw, TMO, 0, 0);
    // reset during a load's memory wait aborts it without write-back
    c = idle(ST_FETCH);
    c.mem_req = 1; c.ir_write = 1; c.pc_write = 1; c.src_b = 2'b01; c.op = K_ADD;
    mem_phase(i_lw, ST_FETCH, 0, c, to);
    c = idle(ST_DECODE); c.src_a = 2'b01; c.src_b = 2'b10; c.op = K_ADD;
    push(i_lw, 0, 0, c);
    c = idle(ST_MEMADDR); c.src_a = 2'b10; c.src_b = 2'b10; c.op = K_ADD;
    push(i_lw, 0, 0, c);
    c = idle(ST_MEMREAD); c.mem_req = 1; c.i_or_d = 1;
    push(i_lw, 0, 0, c);
    push(i_lw, 0, 0, c);
    push_rst(i_lw);
    do_instr(i_add, 0, 0, 0);
    // randomized instruction stream
    for (int n = 0; n < 150; n++)
      do_instr(rand_instr(), $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1), 1'($urandom));

    reset = 1; instr = '0; mem_ready = 0; alu_zero = 0;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      #1;
      reset     = vq[i].rst;
      instr     = vq[i].ins;
      mem_ready = vq[i].rdy;
      alu_zero  = vq[i].zero;
      @(negedge clk);
      if (vq[i].chk) begin
        act = '{mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
                alu_op, pc_src, wb_sel, instr_retired, trap, trap_cause, state};
        n_tests++;
        if (act !== vq[i].exp) begin
          n_fail++;
          $display("FAIL ctl vec %0d instr %h: got %h required %h", i, vq[i].ins, act, vq[i].exp);
        end
        if (vq[i].exp.retired) exp_ret++;
        if (instr_retired === 1'b1) got_ret++;
      end
      @(posedge clk);
    end
    n_tests++;
    if (got_ret != exp_ret) begin
      n_fail++;
      $display("FAIL retire_count: got %0d required %0d", got_ret, exp_ret);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
